// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b cache line and memory arbiter types
package lc3b_types;

    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D,
        ARB_DONE
    } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between I-cache fills and D-cache fills/writebacks
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_W = 128,
    parameter bit FAIR   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [15:0]       i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [15:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    lc3b_arb_state state_q, state_d;
    logic          d_turn_q, d_turn_d;
    logic          d_req, grant_i, grant_d;

    // d_turn is set after reset and after every I transfer, so fair contention alternates starting with D
    always_comb begin
        d_req    = d_pmem_read | d_pmem_write;
        grant_i  = state_q == ARB_GRANT_I;
        grant_d  = state_q == ARB_GRANT_D;
        state_d  = state_q;
        d_turn_d = d_turn_q;
        case (state_q)
            ARB_IDLE:
                state_d = (d_req && (!i_pmem_read || !FAIR || d_turn_q)) ? ARB_GRANT_D :
                          i_pmem_read ? ARB_GRANT_I : ARB_IDLE;
            ARB_GRANT_I:
                if (pmem_resp) begin
                    state_d  = ARB_DONE;
                    d_turn_d = 1'b1;
                end
            ARB_GRANT_D:
                if (pmem_resp) begin
                    state_d  = ARB_DONE;
                    d_turn_d = 1'b0;
                end
            default:
                state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            d_turn_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            d_turn_q <= d_turn_d;
        end
    end

    assign pmem_read    = grant_i ? i_pmem_read : (grant_d && d_pmem_read && !d_pmem_write);
    assign pmem_write   = grant_d && d_pmem_write;
    assign pmem_address = grant_i ? i_pmem_address : grant_d ? d_pmem_address : 16'h0;
    assign pmem_wdata   = grant_d ? d_pmem_wdata : '0;
    assign i_pmem_resp  = grant_i && pmem_resp;
    assign d_pmem_resp  = grant_d && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter (FAIR=0 and FAIR=1) against a transfer-level model
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd [2];
    logic [15:0]  i_addr [2];
    logic         d_rd [2];
    logic         d_wr [2];
    logic [15:0]  d_addr [2];
    logic [127:0] d_wd [2];
    logic [127:0] p_rdata [2];
    logic         p_resp [2];
    logic [127:0] i_rdata_o [2];
    logic [127:0] d_rdata_o [2];
    logic         i_resp_o [2];
    logic         d_resp_o [2];
    logic         p_rd_o [2];
    logic         p_wr_o [2];
    logic [15:0]  p_addr_o [2];
    logic [127:0] p_wd_o [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   owner [2];
    bit   cool [2];
    bit   d_turn [2];
    bit   seen_i [2];
    bit   seen_d [2];
    logic [3:0] glog [2];
    int   gcnt [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.LINE_W(128), .FAIR(g == 1)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .i_pmem_read    (i_rd[g]),
            .i_pmem_address (i_addr[g]),
            .i_pmem_rdata   (i_rdata_o[g]),
            .i_pmem_resp    (i_resp_o[g]),
            .d_pmem_read    (d_rd[g]),
            .d_pmem_write   (d_wr[g]),
            .d_pmem_address (d_addr[g]),
            .d_pmem_wdata   (d_wd[g]),
            .d_pmem_rdata   (d_rdata_o[g]),
            .d_pmem_resp    (d_resp_o[g]),
            .pmem_read      (p_rd_o[g]),
            .pmem_write     (p_wr_o[g]),
            .pmem_address   (p_addr_o[g]),
            .pmem_wdata     (p_wd_o[g]),
            .pmem_rdata     (p_rdata[g]),
            .pmem_resp      (p_resp[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // owner: 0 none, 1 I-side transfer, 2 D-side transfer; cool marks the turnaround cycle after a resp
    task automatic model_step(input int k);
        bit dq;
        dq = d_rd[k] || d_wr[k];
        if (reset) begin
            owner[k]  = 0;
            cool[k]   = 1'b0;
            d_turn[k] = 1'b1;
        end else if (cool[k]) begin
            cool[k] = 1'b0;
        end else if (owner[k] != 0) begin
            if (p_resp[k]) begin
                d_turn[k] = owner[k] == 1;
                owner[k]  = 0;
                cool[k]   = 1'b1;
            end
        end else if (dq && i_rd[k]) begin
            owner[k] = (k == 0 || d_turn[k]) ? 2 : 1;
        end else if (dq) begin
            owner[k] = 2;
        end else if (i_rd[k]) begin
            owner[k] = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
    endtask

    task automatic verify();
        #3;
        for (int k = 0; k < 2; k++) begin
            logic        gi, gd, e_rd, e_wr;
            logic [15:0] e_addr;
            gi     = owner[k] == 1;
            gd     = owner[k] == 2;
            e_rd   = gi ? i_rd[k] : (gd && d_rd[k] && !d_wr[k]);
            e_wr   = gd && d_wr[k];
            e_addr = gi ? i_addr[k] : gd ? d_addr[k] : 16'h0;
            check($sformatf("ctl[%0d]", k), {p_rd_o[k], p_wr_o[k], i_resp_o[k], d_resp_o[k], p_addr_o[k]},
                  {e_rd, e_wr, gi && p_resp[k], gd && p_resp[k], e_addr});
            check($sformatf("wdata[%0d]", k), p_wd_o[k], gd ? d_wd[k] : 128'h0);
            check($sformatf("i_rdata[%0d]", k), i_rdata_o[k], p_rdata[k]);
            check($sformatf("d_rdata[%0d]", k), d_rdata_o[k], p_rdata[k]);
            seen_i[k] = i_resp_o[k];
            seen_d[k] = d_resp_o[k];
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_rd[k]    = 1'b0;
            i_addr[k]  = 16'h0;
            d_rd[k]    = 1'b0;
            d_wr[k]    = 1'b0;
            d_addr[k]  = 16'h0;
            d_wd[k]    = 128'h0;
            p_rdata[k] = 128'h0;
            p_resp[k]  = 1'b0;
        end
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 199) == 0);
        for (int k = 0; k < 2; k++) begin
            if (i_rd[k] && seen_i[k]) i_rd[k] = 1'b0;
            if (!i_rd[k] && $urandom_range(0, 3) == 0) begin
                i_rd[k]   = 1'b1;
                i_addr[k] = 16'($urandom);
            end
            if ((d_rd[k] || d_wr[k]) && seen_d[k]) begin
                d_rd[k] = 1'b0;
                d_wr[k] = 1'b0;
            end
            if (!(d_rd[k] || d_wr[k]) && $urandom_range(0, 3) == 0) begin
                d_wr[k]   = $urandom_range(0, 1) == 1;
                d_rd[k]   = !d_wr[k];
                d_addr[k] = 16'($urandom);
                d_wd[k]   = {$urandom, $urandom, $urandom, $urandom};
            end
            p_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
            p_resp[k]  = (owner[k] != 0 && !cool[k]) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        verify();
        for (int k = 0; k < 2; k++)
            check($sformatf("rst_out[%0d]", k), {p_rd_o[k], p_wr_o[k], i_resp_o[k], d_resp_o[k], p_addr_o[k], p_wd_o[k]}, '0);
        cycle();

        // I-only read, memory answers on the third granted cycle
        i_rd[0]    = 1'b1;
        i_addr[0]  = 16'h1230;
        p_rdata[0] = {16{8'hA5}};
        verify();
        cycle();
        verify();
        check("t1_grant", {p_rd_o[0], p_addr_o[0]}, {1'b1, 16'h1230});
        cycle();
        verify();
        cycle();
        p_resp[0] = 1'b1;
        verify();
        check("t1_resp", {i_resp_o[0], d_resp_o[0], i_rdata_o[0]}, {1'b1, 1'b0, {16{8'hA5}}});
        cycle();
        p_resp[0] = 1'b0;
        i_rd[0]   = 1'b0;
        verify();
        check("t1_resp_drop", {i_resp_o[0], p_rd_o[0]}, 2'b00);
        cycle();
        verify();
        cycle();

        // simultaneous I read and D write on the D-priority instance
        i_rd[0]   = 1'b1;
        i_addr[0] = 16'h0040;
        d_wr[0]   = 1'b1;
        d_addr[0] = 16'h8000;
        d_wd[0]   = {8{16'h1111}};
        verify();
        cycle();
        p_resp[0] = 1'b1;
        verify();
        check("t2_dgrant", {p_wr_o[0], p_rd_o[0], p_addr_o[0], d_resp_o[0], i_resp_o[0]}, {2'b10, 16'h8000, 2'b10});
        check("t2_dwdata", p_wd_o[0], {8{16'h1111}});
        cycle();
        p_resp[0] = 1'b0;
        d_wr[0]   = 1'b0;
        verify();
        check("t2_done", {p_rd_o[0], p_wr_o[0]}, 2'b00);
        cycle();
        verify();
        check("t2_idle", {p_rd_o[0], p_wr_o[0]}, 2'b00);
        cycle();
        verify();
        check("t2_igrant", {p_rd_o[0], p_wr_o[0], p_addr_o[0]}, {2'b10, 16'h0040});
        p_resp[0] = 1'b1;
        verify();
        check("t2_iresp", {i_resp_o[0], d_resp_o[0]}, 2'b10);
        cycle();
        p_resp[0] = 1'b0;
        i_rd[0]   = 1'b0;
        verify();
        cycle();
        verify();
        cycle();

        // both sides request continuously on both instances, memory answers immediately
        for (int k = 0; k < 2; k++) begin
            i_rd[k]   = 1'b1;
            i_addr[k] = 16'h0400;
            d_rd[k]   = 1'b1;
            d_addr[k] = 16'h0600;
            glog[k]   = 4'h0;
            gcnt[k]   = 0;
        end
        for (int c = 0; c < 16; c++) begin
            #1;
            for (int k = 0; k < 2; k++) p_resp[k] = p_rd_o[k] || p_wr_o[k];
            verify();
            for (int k = 0; k < 2; k++)
                if ((d_resp_o[k] || i_resp_o[k]) && gcnt[k] < 4) begin
                    glog[k][3 - gcnt[k]] = d_resp_o[k];
                    gcnt[k]++;
                end
            cycle();
        end
        check("order_fair0", {28'h0, glog[0]}, {28'h0, 4'b1111});
        check("order_fair1", {28'h0, glog[1]}, {28'h0, 4'b1010});
        clear_inputs();
        reset = 1'b1;
        verify();
        cycle();
        reset = 1'b0;

        // reset in the middle of a D grant abandons it
        d_rd[0]   = 1'b1;
        d_addr[0] = 16'h0200;
        verify();
        cycle();
        verify();
        check("t4_grant", {p_rd_o[0], p_addr_o[0]}, {1'b1, 16'h0200});
        reset = 1'b1;
        verify();
        cycle();
        reset = 1'b0;
        verify();
        check("t4_after_rst", {p_rd_o[0], p_wr_o[0], d_resp_o[0], p_addr_o[0]}, {3'b000, 16'h0});
        cycle();
        p_resp[0] = 1'b1;
        verify();
        check("t4_regrant", {p_rd_o[0], d_resp_o[0], p_addr_o[0]}, {2'b11, 16'h0200});
        cycle();
        p_resp[0] = 1'b0;
        d_rd[0]   = 1'b0;
        verify();
        cycle();
        verify();
        cycle();

        // spurious memory resp in IDLE together with a new D read
        p_resp[0] = 1'b1;
        d_rd[0]   = 1'b1;
        d_addr[0] = 16'h0100;
        verify();
        check("t5_spurious", {i_resp_o[0], d_resp_o[0], p_rd_o[0]}, 3'b000);
        cycle();
        p_resp[0] = 1'b0;
        verify();
        check("t5_grant", {p_rd_o[0], p_addr_o[0], d_resp_o[0]}, {1'b1, 16'h0100, 1'b0});
        p_resp[0] = 1'b1;
        verify();
        cycle();
        clear_inputs();
        verify();
        cycle();

        for (int c = 0; c < 2000; c++) begin
            rand_inputs();
            verify();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
